// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x-oversampling UART receiver, 8N1 by default, LSB first.
// Synchronises rx, qualifies the start bit at mid-cell, samples each data bit
// on the 16th oversample tick and presents the word with a sticky ready flag.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit (8E1).
module uart_rx_os16 #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_50m,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rxclk_en,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 rdy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_s;

    state_e                 state_q, state_d;
    logic [3:0]             sample_q, sample_d;
    logic [CNT_W-1:0]       bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   rdy_q, rdy_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;

    // Shift rx through the synchroniser chain every clock, independent of rxclk_en.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Synchroniser register; resets to the idle-high line level.
    always_ff @(posedge clk_50m) begin
        // NOTE: sequential blocks use non-blocking assignments only, so every
        // flop samples the pre-edge value of its neighbours.
        if (rst) sync_q <= '1;
        else     sync_q <= sync_d;
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_q, parity_err_d;
`endif

    // Next-state and output logic for the receive FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        sample_d    = sample_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        rdy_d       = rdy_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif

        // Bus clear; a word completing in the same cycle overrides it below.
        if (rdy_clr) begin
            rdy_d     = 1'b0;
            overrun_d = 1'b0;
        end

        if (rxclk_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d  = S_START;
                        sample_d = 4'd0;
                    end
                end
                S_START: begin
                    sample_d = sample_q + 4'd1;
                    if (sample_q == 4'd7) begin
                        sample_d = 4'd0;
                        bitcnt_d = '0;
                        state_d  = rx_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    sample_d = sample_q + 4'd1;
                    if (sample_q == 4'd15) begin
                        shift_d[bitcnt_q] = rx_s;
                        bitcnt_d          = bitcnt_q + CNT_W'(1);
                        sample_d          = 4'd0;
                        if (bitcnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    sample_d = sample_q + 4'd1;
                    if (sample_q == 4'd15) begin
                        parity_err_d = (^shift_q) ^ rx_s;
                        sample_d     = 4'd0;
                        state_d      = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    sample_d = sample_q + 4'd1;
                    if (sample_q == 4'd15) begin
                        if (rx_s) begin
                            data_d      = shift_q;
                            rdy_d       = 1'b1;
                            frame_err_d = 1'b0;
                            if (rdy_q && !rdy_clr) overrun_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                        sample_d = 4'd0;
                        state_d  = S_IDLE;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    sample_d = 4'd0;
                end
            endcase
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sample_q    <= 4'd0;
            bitcnt_q    <= '0;
            data_q      <= '0;
            rdy_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sample_q    <= sample_d;
            bitcnt_q    <= bitcnt_d;
            data_q      <= data_d;
            rdy_q       <= rdy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Assembly register for incoming bits.
    always_ff @(posedge clk_50m) begin
        // NOTE: no reset needed; every bit is rewritten in each frame before
        // the word can be copied to data.
        shift_q <= shift_d;
    end

`ifdef UART_RX_PARITY_EN
    // Parity error flag, updated at the parity sample.
    always_ff @(posedge clk_50m) begin
        if (rst) parity_err_q <= 1'b0;
        else     parity_err_q <= parity_err_d;
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign data      = data_q;
    assign rdy       = rdy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
